// File: rtl/n_serial_sub_pkg.sv
// n_serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   sub_state_t : controller states (IDLE, BUSY, DONE)
//   cnt_w()     : bit-counter width needed to count up to n
package n_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational subtract cell, d = a - b - bin.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/n_serial_subtractor.sv
// n_serial_subtractor: bit-serial signed N-bit subtractor, D = A - B - bi, LSB first,
// one bit per clock; result is ready N cycles after the operands are accepted.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready depends combinationally on out_ready)
//   A, B, bi             : signed minuend, signed subtrahend, borrow in
//   out_valid, out_ready : result handshake
//   D, bo, ovf           : difference, unsigned borrow out, signed overflow
// Build option: define SERIAL_SUB_SAT_EN to saturate D on signed overflow.
module n_serial_subtractor
    import n_serial_sub_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         bo,
    output logic         ovf
);

    localparam int unsigned CntW = cnt_w(N);

    sub_state_t state_q, state_d;

    logic [N-1:0]    a_q, b_q, res_q;
    logic            brw_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]    d_q;
    logic            bo_q, ovf_q, out_valid_q;

    logic            accept;
    logic            last_bit;
    logic            d_bit, bout_bit;
    logic            brw_msb_in;
    logic            ovf_bit;
    logic [N-1:0]    res_next;
    logic [N-1:0]    d_final;

    // Single serial cell: operands are consumed from bit 0 of the shift registers.
    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == BUSY) && (cnt_q == CntW'(N - 1));
    assign res_next = {d_bit, res_q[N-1:1]};

    // During the MSB cycle brw_q is still the borrow into the sign bit.
    assign brw_msb_in = brw_q;
    assign ovf_bit    = brw_msb_in ^ bout_bit;

`ifdef SERIAL_SUB_SAT_EN
    // a_q[0] holds the original sign of A during the MSB cycle.
    always_comb begin
        d_final = res_next;
        if (ovf_bit) begin
            d_final = a_q[0] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign d_final = res_next;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (last_bit) state_d = DONE;
            DONE: begin
                if (out_ready) state_d = accept ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: in_ready allows back-to-back handoff from DONE.
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            brw_q <= 1'b0;
            cnt_q <= '0;
            d_q   <= '0;
            bo_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            brw_q <= bi;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            brw_q <= bout_bit;
            res_q <= res_next;
            cnt_q <= cnt_q + CntW'(1);
            if (last_bit) begin
                d_q   <= d_final;
                bo_q  <= bout_bit;
                ovf_q <= ovf_bit;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign bo        = bo_q;
    assign ovf       = ovf_q;

endmodule
